// File: rtl/ahb_noc_pkg.sv
// ahb_noc_pkg: shared AHB transfer/burst encodings and arbiter state type
// Contents: htrans_e, hburst_e, arb_state_e, burst_beats() (beats left after a NONSEQ accept)
package ahb_noc_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {PARK, OWN, BURST, LOCKED} arb_state_e;

    function automatic logic [3:0] burst_beats(input hburst_e b);
        return (b == HBURST_WRAP4  || b == HBURST_INCR4)  ? 4'd3 :
               (b == HBURST_WRAP8  || b == HBURST_INCR8)  ? 4'd7 :
               (b == HBURST_WRAP16 || b == HBURST_INCR16) ? 4'd15 : 4'd0;
    endfunction

endpackage

// File: rtl/ahb_noc_rr_pick.sv
// ahb_noc_rr_pick: combinational rotate-priority picker
// Ports: req (request vector), ptr (last winner, lowest priority) -> gnt (one-hot), idx, valid
module ahb_noc_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int W = $clog2(N);

    // Scan ptr+1 .. ptr+N so the previous winner is considered last
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            if (!valid && req[(int'(ptr) + i) % N]) begin
                valid = 1'b1;
                idx   = W'((int'(ptr) + i) % N);
            end
        end
    end

    assign gnt = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/ahb_noc_arbiter.sv
// ahb_noc_arbiter: round-robin AHB-lite arbiter with burst/lock hold and data-phase tracking
// Ports: HCLK, HRESETn (async active-low), HBUSREQ/HLOCK/HTRANS_M/HBURST_M per master, HREADY;
//        outputs HGRANT (one-hot), HMASTER, HMASTER_D, HMASTLOCK, all registered.
// Option: AHB_NOC_ARB_STATS_EN adds stat_clr (in) and stat_grants (32-bit per-master grant counts).
module ahb_noc_arbiter
    import ahb_noc_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DEF_MASTER  = 0
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic [NUM_MASTERS-1:0]         HBUSREQ,
    input  logic [NUM_MASTERS-1:0]         HLOCK,
    input  logic [2*NUM_MASTERS-1:0]       HTRANS_M,
    input  logic [3*NUM_MASTERS-1:0]       HBURST_M,
    input  logic                           HREADY,
    output logic [NUM_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
    output logic [$clog2(NUM_MASTERS)-1:0] HMASTER_D,
    output logic                           HMASTLOCK
`ifdef AHB_NOC_ARB_STATS_EN
    ,
    input  logic                           stat_clr,
    output logic [NUM_MASTERS-1:0][31:0]   stat_grants
`endif
);
    localparam int W = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] DEF_OH = NUM_MASTERS'(1) << DEF_MASTER;

    arb_state_e             state, state_n;
    logic [W-1:0]           ptr, ptr_n, master_n, master_d_n, win;
    logic [NUM_MASTERS-1:0] grant_n, win_oh;
    logic [3:0]             beats, beats_n, beats_acc;
    logic                   lock_n, arb, valid, olock, oreq;
    htrans_e                otrans;
    hburst_e                oburst;

    assign otrans = htrans_e'(HTRANS_M[2*int'(HMASTER) +: 2]);
    assign oburst = hburst_e'(HBURST_M[3*int'(HMASTER) +: 3]);
    assign olock  = HLOCK[HMASTER];
    assign oreq   = HBUSREQ[HMASTER];

    ahb_noc_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req   (HBUSREQ),
        .ptr   (ptr),
        .gnt   (win_oh),
        .idx   (win),
        .valid (valid)
    );

    // Beats left once the current owner's transfer is accepted
    assign beats_acc = (otrans == HTRANS_NONSEQ) ? burst_beats(oburst) :
                       (otrans == HTRANS_SEQ && beats != 4'd0) ? beats - 4'd1 : beats;

    // An unlocked SINGLE completes in one beat, so it releases the bus like a burst end
    assign arb = (state == PARK) ||
                 (state == OWN && (otrans == HTRANS_IDLE || !oreq ||
                                   (otrans == HTRANS_NONSEQ && oburst == HBURST_SINGLE && !olock))) ||
                 (state == BURST && beats_acc == 4'd0) ||
                 (state == LOCKED && !olock);

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        beats_n    = beats;
        master_n   = HMASTER;
        master_d_n = HMASTER_D;
        grant_n    = HGRANT;
        lock_n     = HMASTLOCK;
        if (HREADY) begin
            master_d_n = HMASTER;
            beats_n    = beats_acc;
            if (arb) begin
                state_n  = valid ? OWN : PARK;
                ptr_n    = valid ? win : ptr;
                master_n = valid ? win : W'(DEF_MASTER);
                grant_n  = valid ? win_oh : DEF_OH;
                beats_n  = 4'd0;
                lock_n   = 1'b0;
            end else begin
                state_n = (state == LOCKED) ? LOCKED :
                          (otrans != HTRANS_NONSEQ) ? state :
                          olock ? LOCKED :
                          (burst_beats(oburst) != 4'd0) ? BURST : OWN;
                lock_n  = (state_n == LOCKED);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= PARK;
            ptr       <= W'(DEF_MASTER);
            beats     <= 4'd0;
            HMASTER   <= W'(DEF_MASTER);
            HMASTER_D <= W'(DEF_MASTER);
            HGRANT    <= DEF_OH;
            HMASTLOCK <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            beats     <= beats_n;
            HMASTER   <= master_n;
            HMASTER_D <= master_d_n;
            HGRANT    <= grant_n;
            HMASTLOCK <= lock_n;
        end
    end

`ifdef AHB_NOC_ARB_STATS_EN
    // A handover is a grant leaving PARK or moving to a different master
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            stat_grants <= '0;
        else if (stat_clr)
            stat_grants <= '0;
        else if (HREADY && arb && valid && (state == PARK || win != HMASTER))
            stat_grants[win] <= stat_grants[win] + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ahb_noc_arbiter.sv
// tb_ahb_noc_arbiter: directed self-checking bench for ahb_noc_arbiter
module tb_ahb_noc_arbiter;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SQ = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] HBUSREQ, HLOCK, HGRANT;
    logic [7:0] HTRANS_M;
    logic [11:0] HBURST_M;
    logic       HREADY, HMASTLOCK;
    logic [1:0] HMASTER, HMASTER_D;
`ifdef AHB_NOC_ARB_STATS_EN
    logic             stat_clr;
    logic [3:0][31:0] stat_grants;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    ahb_noc_arbiter dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS_M  (HTRANS_M),
        .HBURST_M  (HBURST_M),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
`ifdef AHB_NOC_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_grants (stat_grants)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_m(input int i, input logic req, input logic lock,
                         input logic [1:0] tr, input logic [2:0] bu);
        HBUSREQ[i]       = req;
        HLOCK[i]         = lock;
        HTRANS_M[2*i+:2] = tr;
        HBURST_M[3*i+:3] = bu;
    endtask

    task automatic owner_is(input string tag, input int m);
        check({tag, "_hmaster"}, 32'(HMASTER), 32'(m));
        check({tag, "_hgrant"}, 32'(HGRANT), 32'(1) << m);
    endtask

    initial begin
        int exp_seq[5] = '{1, 2, 3, 0, 1};
        HRESETn  = 1'b0;
        HREADY   = 1'b1;
        HBUSREQ  = '0;
        HLOCK    = '0;
        HTRANS_M = '0;
        HBURST_M = '0;
`ifdef AHB_NOC_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        tick();
        tick();
        owner_is("reset", 0);
        check("reset_hmaster_d", 32'(HMASTER_D), 32'd0);
        check("reset_hmastlock", 32'(HMASTLOCK), 32'd0);
        HRESETn = 1'b1;

        // Reset asserted in the middle of an INCR8 burst
        set_m(1, 1'b1, 1'b0, NS, INCR8);
        tick();
        owner_is("incr8_grant", 1);
        set_m(2, 1'b1, 1'b0, NS, SINGLE);
        tick();
        check("incr8_hmaster_d", 32'(HMASTER_D), 32'd1);
        set_m(1, 1'b1, 1'b0, SQ, INCR8);
        tick();
        tick();
        owner_is("incr8_beat3", 1);
        #2 HRESETn = 1'b0;
        #1;
        owner_is("async_rst", 0);
        check("async_rst_hmaster_d", 32'(HMASTER_D), 32'd0);
        check("async_rst_hmastlock", 32'(HMASTLOCK), 32'd0);
        set_m(1, 1'b0, 1'b0, IDLE, SINGLE);
        set_m(2, 1'b0, 1'b0, IDLE, SINGLE);
        #2 HRESETn = 1'b1;
        tick();
        owner_is("park_after_rst", 0);

        // All four masters issuing SINGLEs rotate every cycle
        for (int i = 0; i < 4; i++) set_m(i, 1'b1, 1'b0, NS, SINGLE);
        for (int k = 0; k < 5; k++) begin
            tick();
            owner_is($sformatf("rr%0d", k), exp_seq[k]);
            if (k == 1) check("rr_hmaster_d", 32'(HMASTER_D), 32'd1);
        end

        // Wait states during a pending handover freeze everything
        HREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            owner_is($sformatf("wait%0d", k), 1);
            check($sformatf("wait%0d_hmaster_d", k), 32'(HMASTER_D), 32'd0);
        end
        HREADY = 1'b1;
        tick();
        owner_is("wait_release", 2);
        check("wait_release_hmaster_d", 32'(HMASTER_D), 32'd1);

        // m2 INCR4 with a BUSY beat, m1 waiting; handover on the last SEQ accept
        set_m(0, 1'b0, 1'b0, IDLE, SINGLE);
        set_m(3, 1'b0, 1'b0, IDLE, SINGLE);
        set_m(2, 1'b1, 1'b0, NS, INCR4);
        tick();
        owner_is("incr4_ns", 2);
        set_m(2, 1'b1, 1'b0, SQ, INCR4);
        tick();
        owner_is("incr4_seq1", 2);
        set_m(2, 1'b1, 1'b0, BUSY, INCR4);
        tick();
        owner_is("incr4_busy", 2);
        set_m(2, 1'b1, 1'b0, SQ, INCR4);
        tick();
        owner_is("incr4_seq2", 2);
        tick();
        owner_is("incr4_end", 1);
        check("incr4_end_hmaster_d", 32'(HMASTER_D), 32'd2);

        // m3 locked pair of SINGLEs while m0/m1 request
        set_m(2, 1'b0, 1'b0, IDLE, SINGLE);
        set_m(0, 1'b1, 1'b0, NS, SINGLE);
        set_m(3, 1'b1, 1'b1, NS, SINGLE);
        tick();
        owner_is("lock_grant", 3);
        check("lock_grant_mastlock", 32'(HMASTLOCK), 32'd0);
        tick();
        owner_is("lock_1", 3);
        check("lock_1_mastlock", 32'(HMASTLOCK), 32'd1);
        tick();
        owner_is("lock_2", 3);
        check("lock_2_mastlock", 32'(HMASTLOCK), 32'd1);
        set_m(3, 1'b0, 1'b0, IDLE, SINGLE);
        HREADY = 1'b0;
        tick();
        owner_is("lock_drop_wait", 3);
        check("lock_drop_wait_mastlock", 32'(HMASTLOCK), 32'd1);
        HREADY = 1'b1;
        tick();
        owner_is("lock_release", 0);
        check("lock_release_mastlock", 32'(HMASTLOCK), 32'd0);

`ifdef AHB_NOC_ARB_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_pre_clr", stat_grants[1], 32'd0);
        for (int i = 0; i < 4; i++) set_m(i, 1'b1, 1'b0, NS, SINGLE);
        for (int k = 0; k < 40; k++) tick();
        check("stat_m1", stat_grants[1], 32'd10);
        check("stat_m2", stat_grants[2], 32'd10);
        check("stat_m0", stat_grants[0], 32'd10);
        for (int i = 0; i < 4; i++) set_m(i, 1'b0, 1'b0, IDLE, SINGLE);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_clr", stat_grants[1], 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
